// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
//   XLEN           : instruction / PC / immediate width (32 only)
//   OPC_*          : base opcode encodings
//   instr_class_e  : 3-bit instruction class reported downstream
//   decoded_t      : one decoded instruction as stored in the output buffer
package decode_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_IALU   = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_UPPER  = 3'd5,
    CLS_JUMP   = 3'd6,
    CLS_SYS    = 3'd7
  } instr_class_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      shamt;
    instr_class_e    cls;
    logic            illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
//   in_valid/in_ready/in_instr/in_pc : fetch -> decode push channel
//   flush                            : discard buffered and incoming entries
//   out_valid/out_ready/out_*        : decode -> execute head-of-buffer channel
// master = environment (fetch + execute), slave = decode_stage.
interface decode_stage_if;
  import decode_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_shamt;
  logic [2:0]      out_class;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_shamt, out_class, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_shamt, out_class, out_illegal
  );

endinterface

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I decoder: raw instruction + PC -> decoded_t.
//   instr  : raw 32-bit instruction
//   pc     : PC of instr, passed through
//   dec_c  : decoded bundle (illegal encodings report class SYS and imm 0)
// CSR_EN = 0 turns the SYSTEM opcode into an illegal encoding.
module rv32_decode_comb
  import decode_pkg::*;
#(
  parameter bit CSR_EN = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec_c
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [31:0]  imm_i;
  logic [31:0]  imm_s;
  logic [31:0]  imm_b;
  logic [31:0]  imm_u;
  logic [31:0]  imm_j;
  instr_class_e cls;
  logic [31:0]  imm;
  logic         bad;
  logic         f7_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign f7_ok  = (funct7 == F7_BASE) || (funct7 == F7_ALT);

  // Immediate formats, all sign-extended from instr[31].
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Class, immediate select and legality per opcode.
  always_comb begin
    cls = CLS_SYS;
    imm = '0;
    bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        cls = CLS_R;
        if (!f7_ok) bad = 1'b1;
        else if ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101)) bad = 1'b1;
      end
      OPC_OP_IMM: begin
        cls = CLS_IALU;
        imm = imm_i;
        // Only the shift forms carry a funct7 field.
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          if (!f7_ok) bad = 1'b1;
          else if ((funct7 == F7_ALT) && (funct3 == 3'b001)) bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        cls = CLS_LOAD;
        imm = imm_i;
      end
      OPC_STORE: begin
        cls = CLS_STORE;
        imm = imm_s;
      end
      OPC_BRANCH: begin
        cls = CLS_BRANCH;
        imm = imm_b;
        if ((funct3 == 3'b010) || (funct3 == 3'b011)) bad = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        cls = CLS_UPPER;
        imm = imm_u;
      end
      OPC_JAL: begin
        cls = CLS_JUMP;
        imm = imm_j;
      end
      OPC_JALR: begin
        cls = CLS_JUMP;
        imm = imm_i;
        if (funct3 != 3'b000) bad = 1'b1;
      end
      OPC_SYSTEM: begin
        cls = CLS_SYS;
        imm = imm_i;
        if (!CSR_EN) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
  end

  // Raw fields always pass through; illegal entries force class SYS, imm 0.
  always_comb begin
    dec_c         = '0;
    dec_c.pc      = pc;
    dec_c.opcode  = opcode;
    dec_c.funct3  = funct3;
    dec_c.funct7  = funct7;
    dec_c.rd      = instr[11:7];
    dec_c.rs1     = instr[19:15];
    dec_c.rs2     = instr[24:20];
    dec_c.shamt   = instr[24:20];
    dec_c.imm     = bad ? 32'h0 : imm;
    dec_c.cls     = bad ? CLS_SYS : cls;
    dec_c.illegal = bad;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a DEPTH-entry circular output buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode_stage_if.slave (fetch push channel, flush, execute head channel)
// Parameters: XLEN (32 only), DEPTH (power of two, >= 1), CSR_EN.
// in_ready and out_valid are flops updated from the next occupancy, so in_ready
// never depends combinationally on out_ready.
module decode_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 2,
  parameter bit          CSR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_stage_if.slave  bus
);

  import decode_pkg::*;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  decoded_t         dec_c;
  decoded_t         mem [DEPTH];
  decoded_t         head;
  logic [XLEN-1:0]  pc_in;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             valid_q;
  logic             ready_q;
  logic             push_c;
  logic             pop_c;

  assign pc_in = bus.in_pc;

  rv32_decode_comb #(
    .CSR_EN (CSR_EN)
  ) u_decode (
    .instr (bus.in_instr),
    .pc    (pc_in),
    .dec_c (dec_c)
  );

  // Flush masks both handshakes for the cycle it is asserted.
  assign push_c = bus.in_valid && ready_q && !bus.flush;
  assign pop_c  = valid_q && bus.out_ready && !bus.flush;

  // Next pointers and occupancy.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push_c) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Pointer, occupancy and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      valid_q <= (count_nxt != '0);
      ready_q <= (count_nxt < FULL_CNT);
    end
  end

  // Entry storage; cleared on reset so head fields read 0 afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= dec_c;
    end
  end

  assign head = mem[rd_ptr];

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = head.pc;
  assign bus.out_opcode  = head.opcode;
  assign bus.out_funct3  = head.funct3;
  assign bus.out_funct7  = head.funct7;
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_imm     = head.imm;
  assign bus.out_shamt   = head.shamt;
  assign bus.out_class   = head.cls;
  assign bus.out_illegal = head.illegal;

endmodule
